// File: rtl/accumulator_control_unit.sv
// Multicycle control unit for the accumulator CPU: fetch, execute and write-back sequencing, program counter, control strobes.
// Latency: strobes appear 1 cycle after the fetch handshake (a_we for ALU ops 2 cycles after).
// Backpressure: instr_ready is high only in FETCH; the unit stalls in FETCH while instr_valid is low.
module accumulator_control_unit #(
    parameter  int INSTR_W   = 16,
    parameter  int NUM_REGS  = 4,
    parameter  int PC_W      = 8,
    localparam int RF_ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 instr_ready,
    output logic [PC_W-1:0]      pc,
    output logic [2:0]           alu_opcode,
    output logic                 alu_ce,
    output logic [RF_ADDR_W-1:0] rf_addr,
    output logic                 rf_we,
    output logic                 a_we,
    output logic [1:0]           a_src,
    output logic [INSTR_W-5:0]   imm,
    input  logic                 acc_zero,
    output logic                 halted,
    output logic                 illegal
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1001;
    localparam logic [3:0] OP_STORE = 4'b1010;
    localparam logic [3:0] OP_LOADI = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_JZ    = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_RF  = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;

    logic                 ready_c;
    logic                 alu_ce_c;
    logic                 rf_we_c;
    logic                 a_we_c;
    logic [1:0]           a_src_c;
    logic                 halted_c;
    logic                 illegal_c;

    logic [3:0]           opcode;
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      target;

    assign opcode = ir_q[3:0];
    assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign target = ir_q[4 +: PC_W];

    // State, program counter and instruction register; reset restores FETCH, pc 0 and a NOP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= {{(INSTR_W-4){1'b0}}, OP_NOP};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, pc update and single-cycle strobe decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ready_c   = 1'b0;
        alu_ce_c  = 1'b0;
        rf_we_c   = 1'b0;
        a_we_c    = 1'b0;
        a_src_c   = SRC_ALU;
        halted_c  = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                ready_c = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                if (!opcode[3]) begin
                    // ALU result is written back next cycle; pc advances from WB.
                    alu_ce_c = 1'b1;
                    pc_d     = pc_q;
                    state_d  = S_WB;
                end else begin
                    case (opcode)
                        OP_NOP:   ;
                        OP_LOAD:  begin a_src_c = SRC_RF;  a_we_c = 1'b1; end
                        OP_STORE: rf_we_c = 1'b1;
                        OP_LOADI: begin a_src_c = SRC_IMM; a_we_c = 1'b1; end
                        OP_JMP:   pc_d = target;
                        OP_JZ:    pc_d = acc_zero ? target : pc_inc;
                        OP_HALT:  begin pc_d = pc_q; state_d = S_HALT; end
                        default:  illegal_c = 1'b1;
                    endcase
                end
            end
            S_WB: begin
                a_src_c = SRC_ALU;
                a_we_c  = 1'b1;
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes and status are forced low while reset is asserted so a reset
    // landing mid-instruction cannot emit a stray write.
    assign instr_ready = rst_n & ready_c;
    assign alu_ce      = rst_n & alu_ce_c;
    assign rf_we       = rst_n & rf_we_c;
    assign a_we        = rst_n & a_we_c;
    assign a_src       = rst_n ? a_src_c : SRC_ALU;
    assign halted      = rst_n & halted_c;
    assign illegal     = rst_n & illegal_c;

    assign pc          = pc_q;
    assign alu_opcode  = ir_q[2:0];
    assign rf_addr     = ir_q[INSTR_W-1 -: RF_ADDR_W];
    assign imm         = ir_q[INSTR_W-1:4];

endmodule

// File: doc/accumulator_control_unit.md
Name: accumulator_control_unit

Overview:
- Multicycle control unit for the accumulator CPU; parametrised successor to the combinational instruction decoder.
- Fetches instructions from instruction memory over a valid/ready handshake and holds the current instruction in an internal instruction register.
- Sequences each instruction through a state machine, owns the program counter, and drives single-cycle control strobes for the ALU, register file and accumulator.
- Adds immediate load, jumps, conditional branch, halt and illegal-opcode detection.

Parameters:
- INSTR_W, 16, instruction width in bits.
- NUM_REGS, 4, register-file depth; power of two, at least 2.
- RF_ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.
- PC_W, 8, program counter width; must satisfy PC_W <= INSTR_W-4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr_valid  in  1  instruction memory presents a valid instruction.
- instr  in  INSTR_W  instruction word; sampled only on handshake.
- instr_ready  out  1  control unit accepts an instruction.
- pc  out  PC_W  address of the instruction being fetched or executed.
- alu_opcode  out  3  ALU operation; held from the instruction register.
- alu_ce  out  1  ALU clock-enable strobe.
- rf_addr  out  RF_ADDR_W  register-file address = instr[INSTR_W-1 -: RF_ADDR_W] of the held instruction.
- rf_we  out  1  register-file write strobe; writes the accumulator to rf_addr.
- a_we  out  1  accumulator write strobe.
- a_src  out  2  accumulator source: 0 = ALU, 1 = RF, 2 = immediate.
- imm  out  INSTR_W-4  immediate or target field = instr[INSTR_W-1:4].
- acc_zero  in  1  accumulator-equals-zero flag from the datapath.
- halted  out  1  high while in the HALT state.
- illegal  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Opcode field is instr[3:0].
  - 0xxx: ALU op; alu_opcode = instr[2:0].
  - 1000: NOP.
  - 1001: LOAD, A <- RF[r].
  - 1010: STORE, RF[r] <- A.
  - 1011: LOADI, A <- imm.
  - 1100: JMP.
  - 1101: JZ.
  - 1111: HALT.
  - 1110: illegal.
- States: FETCH, EXEC, WB, HALT.
- Reset (rst_n=0 at an edge, including mid-instruction):
  - State goes to FETCH; pc=0; instruction register cleared to NOP.
  - alu_ce, rf_we, a_we, illegal all 0; a_src=0; halted=0.
  - instr_ready=0 during reset, 1 in the first cycle after.
- FETCH:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr and go to EXEC.
  - Otherwise stay in FETCH; no strobes.
- instr_ready is 0 in all other states; instr_valid is ignored there.
- EXEC (one cycle), per opcode:
  - ALU op: alu_ce=1, then go to WB.
  - LOAD: a_src=1, a_we=1, then go to FETCH.
  - STORE: rf_we=1, then go to FETCH.
  - LOADI: a_src=2, a_we=1, then go to FETCH.
  - NOP: no strobe, then go to FETCH.
  - JMP: pc <= imm[PC_W-1:0], then go to FETCH.
  - JZ: samples acc_zero this cycle. If 1, pc <= imm[PC_W-1:0]; else pc <= pc+1. Then go to FETCH.
  - HALT: go to HALT; pc unchanged.
  - Illegal: illegal=1 for this cycle, treated as NOP.
- WB (ALU ops only): a_src=0, a_we=1, then go to FETCH.
- PC increment: pc <= pc+1 on leaving EXEC (ALU ops leave via WB), except for JMP, taken JZ and HALT.
  - Increment wraps modulo 2^PC_W (all-ones -> 0).
- Instruction latency from handshake: 2 cycles for ALU ops, 1 cycle for all others.
  - Minimum throughput: one instruction per 2 cycles (per 3 for ALU ops).
- Strobes:
  - Every strobe is high for exactly one cycle per instruction.
  - rf_we and a_we are never high in the same cycle.
  - alu_opcode, rf_addr and imm are stable from EXEC until the next handshake.
- HALT: halted=1, instr_ready=0, no strobes; left only by reset.

Test Plan:
- Reset, then instr_valid=1 with ADD (opcode 0001, r=2): instr_ready=1 in the first cycle after reset. alu_ce=1 with alu_opcode=001, rf_addr=2 one cycle later. a_we=1 with a_src=0 in the next cycle; pc=1 back in FETCH.
- Sequence LOADI imm=0x05, STORE r=3, LOAD r=3: a_we with a_src=2, then rf_we with rf_addr=3, then a_we with a_src=1; each strobe is one cycle; pc ends at 3.
- JZ target 0x40 with acc_zero=1 -> pc=0x40. Repeat with acc_zero=0 -> pc increments by 1. JMP 0x7F -> pc=0x7F.
- Execute a NOP at pc=0xFF -> pc wraps to 0x00. Opcode 1110 -> illegal pulses for one cycle, no other strobes, pc advances.
- HALT, then hold instr_valid=1 for 10 cycles -> halted=1, instr_ready=0, no strobes, pc unchanged. Assert rst_n=0 -> pc=0 and halted=0.
- Assert rst_n=0 in WB of an ALU op, and separately with instr_valid stalled low in FETCH -> no a_we after reset; FETCH, pc=0 and all strobes low the next cycle.
